// File: rtl/s4ga_cfg_seq_if.sv
// Host/core bundle of the s4ga configuration sequencer: config RAM write port,
// run control, and the segment stream plus status handed to the LUT core.
interface s4ga_cfg_seq_if #(
  parameter int N    = 101,
  parameter int K    = 5,
  parameter int SI_W = 4
);
  localparam int N_W       = $clog2(N);
  localparam int IDX_SEGS  = (N_W + SI_W - 1) / SI_W;
  localparam int MASK_SEGS = ((1 << K) + SI_W - 1) / SI_W;
  localparam int SEGS      = K * IDX_SEGS + MASK_SEGS;
  localparam int CFG_W     = SEGS * SI_W;

  logic             cfg_we;
  logic [N_W-1:0]   cfg_addr;
  logic [CFG_W-1:0] cfg_wdata;
  logic             start;
  logic [7:0]       frames;
  logic             stop;
  logic             core_rst;
  logic [SI_W-1:0]  core_si;
  logic             busy;
  logic [N_W-1:0]   lut_idx;
  logic             frame_done;
  logic [15:0]      frame_cnt;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, start, frames, stop,
    input  core_rst, core_si, busy, lut_idx, frame_done, frame_cnt
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, start, frames, stop,
    output core_rst, core_si, busy, lut_idx, frame_done, frame_cnt
  );
endinterface

// File: rtl/s4ga_cfg_seq.sv
// Configuration sequencer: stores one config word per LUT and streams them MSB
// segment first into the s4ga core, gapless, after holding the core in reset.
module s4ga_cfg_seq #(
  parameter int N    = 101,
  parameter int K    = 5,
  parameter int SI_W = 4
) (
  input logic           clk,
  input logic           rst,
  s4ga_cfg_seq_if.slave bus
);
  localparam int N_W       = $clog2(N);
  localparam int IDX_SEGS  = (N_W + SI_W - 1) / SI_W;
  localparam int MASK_SEGS = ((1 << K) + SI_W - 1) / SI_W;
  localparam int SEGS      = K * IDX_SEGS + MASK_SEGS;
  localparam int CFG_W     = SEGS * SI_W;
  localparam int SEG_W     = $clog2(SEGS);
  localparam int CNT_W     = $clog2(N + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RESET  = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;

  localparam logic [SEG_W-1:0] SEG_LAST  = SEG_W'(SEGS - 1);
  localparam logic [SEG_W-1:0] SEG_PREV  = SEG_W'(SEGS - 2);
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(N);
  localparam logic [CNT_W-1:0] RST_FETCH = CNT_W'(N - 1);
  localparam logic [N_W-1:0]   LUT_LAST  = N_W'(N - 1);
  localparam logic [N_W:0]     ADDR_LIM  = (N_W + 1)'(N);

  logic [1:0]       state;
  logic [CNT_W-1:0] rst_cnt;
  logic [SEG_W-1:0] seg_cnt;
  logic [7:0]       frames_q;
  logic             stop_pend;

  logic [CFG_W-1:0] ram [N];
  logic [CFG_W-1:0] word_p0;
  logic [CFG_W-1:0] sr_p1;

  logic             fetch_en;
  logic [N_W-1:0]   fetch_addr;
  logic [N_W-1:0]   lut_next;
  logic             seg_load;
  logic             frame_end;
  logic             run_end;
  logic             addr_ok;

  assign addr_ok   = {1'b0, bus.cfg_addr} < ADDR_LIM;
  assign lut_next  = (bus.lut_idx == LUT_LAST) ? '0 : bus.lut_idx + 1'b1;
  assign frame_end = (state == ST_STREAM) && (seg_cnt == SEG_LAST) && (bus.lut_idx == LUT_LAST);
  assign run_end   = frame_end &&
                     (((frames_q != 8'd0) && ((bus.frame_cnt + 16'd1) == {8'd0, frames_q})) ||
                      stop_pend || bus.stop);

  // The next LUT's word is read one edge ahead of its first segment.
  always_comb begin
    fetch_en   = 1'b0;
    fetch_addr = lut_next;
    seg_load   = 1'b0;
    if (state == ST_RESET) begin
      fetch_en   = (rst_cnt == RST_FETCH);
      fetch_addr = '0;
      seg_load   = (rst_cnt == RST_LAST);
    end else if (state == ST_STREAM) begin
      fetch_en = (seg_cnt == SEG_PREV);
      seg_load = (seg_cnt == SEG_LAST);
    end
  end

  // Stage p0: config RAM, read-before-write on a same-edge collision.
  always_ff @(posedge clk) begin
    if (bus.cfg_we && addr_ok) ram[bus.cfg_addr] <= bus.cfg_wdata;
    if (fetch_en) word_p0 <= ram[fetch_addr];
  end

  // Stage p1: segment shifter; its top segment is the one driven next cycle.
  always_ff @(posedge clk) begin
    if (seg_load) sr_p1 <= word_p0 << SI_W;
    else          sr_p1 <= sr_p1 << SI_W;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      rst_cnt        <= '0;
      seg_cnt        <= '0;
      frames_q       <= '0;
      stop_pend      <= 1'b0;
      bus.core_rst   <= 1'b1;
      bus.core_si    <= '0;
      bus.busy       <= 1'b0;
      bus.lut_idx    <= '0;
      bus.frame_done <= 1'b0;
      bus.frame_cnt  <= '0;
    end else begin
      bus.frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state         <= ST_RESET;
            rst_cnt       <= '0;
            frames_q      <= bus.frames;
            stop_pend     <= 1'b0;
            bus.frame_cnt <= '0;
            bus.busy      <= 1'b1;
          end
        end
        ST_RESET: begin
          if (bus.stop) begin
            state    <= ST_IDLE;
            bus.busy <= 1'b0;
          end else if (rst_cnt == RST_LAST) begin
            state        <= ST_STREAM;
            seg_cnt      <= '0;
            bus.lut_idx  <= '0;
            bus.core_rst <= 1'b0;
            bus.core_si  <= word_p0[CFG_W-1 -: SI_W];
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
        ST_STREAM: begin
          if (bus.stop) stop_pend <= 1'b1;
          if ((seg_cnt == SEG_PREV) && (bus.lut_idx == LUT_LAST)) bus.frame_done <= 1'b1;
          if (frame_end) bus.frame_cnt <= bus.frame_cnt + 16'd1;
          if (run_end) begin
            state        <= ST_IDLE;
            seg_cnt      <= '0;
            bus.lut_idx  <= '0;
            bus.busy     <= 1'b0;
            bus.core_rst <= 1'b1;
            bus.core_si  <= '0;
          end else if (seg_cnt == SEG_LAST) begin
            seg_cnt     <= '0;
            bus.lut_idx <= lut_next;
            bus.core_si <= word_p0[CFG_W-1 -: SI_W];
          end else begin
            seg_cnt     <= seg_cnt + 1'b1;
            bus.core_si <= sr_p1[CFG_W-1 -: SI_W];
          end
        end
        default: begin
          state        <= ST_IDLE;
          bus.busy     <= 1'b0;
          bus.core_rst <= 1'b1;
          bus.core_si  <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_s4ga_cfg_seq.sv
// Randomized bench for s4ga_cfg_seq: every cycle is compared against a model that
// derives the expected stream from the cycle count since start and a shadow RAM.
module tb_s4ga_cfg_seq;
  localparam int N         = 101;
  localparam int K         = 5;
  localparam int SI_W      = 4;
  localparam int N_W       = $clog2(N);
  localparam int IDX_SEGS  = (N_W + SI_W - 1) / SI_W;
  localparam int MASK_SEGS = ((1 << K) + SI_W - 1) / SI_W;
  localparam int SEGS      = K * IDX_SEGS + MASK_SEGS;
  localparam int CFG_W     = SEGS * SI_W;
  localparam int FRAME     = N * SEGS;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  s4ga_cfg_seq_if #(.N(N), .K(K), .SI_W(SI_W)) bus ();
  s4ga_cfg_seq #(.N(N), .K(K), .SI_W(SI_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    int               edge_no;
    logic [N_W-1:0]   addr;
    logic [CFG_W-1:0] data;
  } wr_t;

  wr_t              wq[$];
  logic [CFG_W-1:0] mram [N];
  logic             m_run    = 1'b0;
  int               m_c      = 0;
  logic [7:0]       m_frames = '0;
  logic             m_stop_p = 1'b0;
  logic [15:0]      m_fcnt   = '0;
  logic [CFG_W-1:0] m_word   = '0;
  int               ecnt     = 0;
  int               n_cmp    = 0;
  int               n_err    = 0;
  int               sc       = 0;
  int               done_at[$];

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [CFG_W-1:0] rnd_word();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[CFG_W-1:0];
  endfunction

  // One clock: the model consumes the inputs presented to this edge, then the
  // outputs visible after the edge are checked.
  task automatic tick();
    logic i_rst, i_start, i_stop, i_we;
    logic [N_W-1:0] i_addr;
    logic [CFG_W-1:0] i_data;
    logic [7:0] i_frames;
    int k, seg, lut;
    logic e_rst, e_done;
    logic [SI_W-1:0] e_si;
    wr_t w;
    i_rst = rst; i_start = bus.start; i_stop = bus.stop; i_we = bus.cfg_we;
    i_addr = bus.cfg_addr; i_data = bus.cfg_wdata; i_frames = bus.frames;
    @(posedge clk);
    ecnt++;
    if (i_we) begin
      w.edge_no = ecnt; w.addr = i_addr; w.data = i_data;
      wq.push_back(w);
    end
    if (i_rst) begin
      m_run = 1'b0; m_fcnt = '0;
    end else if (!m_run) begin
      if (i_start) begin
        m_run = 1'b1; m_c = 1; m_fcnt = '0; m_frames = i_frames; m_stop_p = 1'b0;
      end
    end else if (m_c <= N + 1) begin
      if (i_stop) m_run = 1'b0;
      else m_c++;
    end else begin
      k = m_c - (N + 1);
      if (k % FRAME == 0) begin
        m_fcnt++;
        if ((m_frames != 0 && m_fcnt == {8'd0, m_frames}) || m_stop_p || i_stop) m_run = 1'b0;
        else m_c++;
      end else begin
        m_c++;
      end
      if (i_stop) m_stop_p = 1'b1;
    end
    #1;
    // A word is used only if written strictly before the edge that fetches it,
    // i.e. two or more edges before the edge that drives its first segment.
    while (wq.size() > 0 && wq[0].edge_no <= ecnt - 2) begin
      w = wq.pop_front();
      if (int'(w.addr) < N) mram[w.addr] = w.data;
    end
    e_rst = 1'b1; e_done = 1'b0; e_si = '0;
    if (m_run && m_c > N + 1) begin
      k   = m_c - (N + 1);
      seg = (k - 1) % SEGS;
      lut = ((k - 1) / SEGS) % N;
      if (seg == 0) m_word = mram[lut];
      e_rst  = 1'b0;
      e_done = (k % FRAME == 0);
      e_si   = SI_W'(m_word >> (CFG_W - (seg + 1) * SI_W));
      check_val("lut_idx", 128'(bus.lut_idx), 128'(lut));
    end
    check_val("core_rst", 128'(bus.core_rst), 128'(e_rst));
    check_val("busy", 128'(bus.busy), 128'(m_run));
    check_val("frame_done", 128'(bus.frame_done), 128'(e_done));
    check_val("core_si", 128'(bus.core_si), 128'(e_si));
    check_val("frame_cnt", 128'(bus.frame_cnt), 128'(m_fcnt));
  endtask

  // Runs until the model says the run is over; sc counts observed stream cycles.
  task automatic observe_run(input int budget, input int stop_at, input int rst_at,
                             input bit rnd_wr, input bit plan_wr);
    bit ended;
    done_at.delete();
    sc = 0;
    ended = 1'b0;
    for (int i = 0; i < budget && !ended; i++) begin
      tick();
      bus.start = 1'b0; bus.stop = 1'b0; bus.cfg_we = 1'b0; rst = 1'b0;
      if (bus.busy && !bus.core_rst) sc++;
      if (bus.frame_done) done_at.push_back(sc);
      if (!m_run) begin
        ended = 1'b1;
      end else begin
        if (sc == stop_at) bus.stop = 1'b1;
        if (sc == rst_at) rst = 1'b1;
        if ($urandom_range(0, 63) == 0) begin
          bus.start = 1'b1; bus.frames = 8'($urandom());
        end
        if (plan_wr && sc == 10 * SEGS + 5) begin
          bus.cfg_we = 1'b1; bus.cfg_addr = N_W'(50); bus.cfg_wdata = rnd_word();
        end else if (plan_wr && sc == 10 * SEGS + 6) begin
          bus.cfg_we = 1'b1; bus.cfg_addr = N_W'(10); bus.cfg_wdata = rnd_word();
        end else if (plan_wr && sc == 10 * SEGS + 7) begin
          bus.cfg_we = 1'b1; bus.cfg_addr = N_W'(101); bus.cfg_wdata = rnd_word();
        end else if (rnd_wr && $urandom_range(0, 39) == 0) begin
          bus.cfg_we = 1'b1; bus.cfg_addr = N_W'($urandom_range(0, 127)); bus.cfg_wdata = rnd_word();
        end
      end
    end
    check_val("run_ended", 128'(ended), 128'(1));
  endtask

  logic [CFG_W-1:0] w0;
  logic [3:0]       first_seq [18];
  int               n, nd, fd;
  logic             rst_low;

  initial begin
    rst = 1'b1;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
    bus.start = 1'b0; bus.frames = '0; bus.stop = 1'b0;
    first_seq = '{4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9, 4'h8, 4'h7,
                  4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1, 4'h0, 4'hA, 4'hB};
    w0 = 72'hFEDCBA9876543210AB;

    // Reset then a long idle stretch.
    repeat (3) tick();
    rst = 1'b0;
    repeat (50) tick();

    for (int i = 0; i < N; i++) begin
      bus.cfg_we = 1'b1; bus.cfg_addr = N_W'(i);
      bus.cfg_wdata = (i == 0) ? w0 : rnd_word();
      tick();
    end
    bus.cfg_we = 1'b0;
    repeat (2) tick();

    // Single-frame run: reset length, first LUT's segments, frame boundary.
    bus.frames = 8'd1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n = 0;
    for (int i = 0; i < 300 && bus.core_rst; i++) begin
      n++;
      tick();
    end
    check_val("reset_len", 128'(n), 128'(N + 1));
    for (int s = 0; s < SEGS; s++) begin
      check_val("first_seg", 128'(bus.core_si), 128'(first_seq[s]));
      check_val("first_lut", 128'(bus.lut_idx), 128'(0));
      tick();
    end
    sc = SEGS + 1; nd = 0; fd = 0;
    for (int i = 0; i < FRAME + 100 && m_run; i++) begin
      if (bus.frame_done) begin
        nd++; fd = sc;
      end
      tick();
      sc++;
    end
    check_val("s2_done_cnt", 128'(nd), 128'(1));
    check_val("s2_done_at", 128'(fd), 128'(FRAME));
    check_val("s2_busy", 128'(bus.busy), 128'(0));
    check_val("s2_core_rst", 128'(bus.core_rst), 128'(1));
    check_val("s2_fcnt", 128'(bus.frame_cnt), 128'(1));
    repeat (5) tick();

    // Three frames back to back with random RAM traffic.
    bus.frames = 8'd3; bus.start = 1'b1;
    observe_run(3 * FRAME + 500, -1, -1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      check_val("s3_done_at", 128'((i < done_at.size()) ? done_at[i] : -1), 128'(FRAME * (i + 1)));
    check_val("s3_done_cnt", 128'(done_at.size()), 128'(3));
    check_val("s3_fcnt", 128'(bus.frame_cnt), 128'(3));
    repeat (5) tick();

    // Continuous run stopped mid-frame, then a fresh start.
    bus.frames = 8'd0; bus.start = 1'b1;
    observe_run(2 * FRAME + 500, 2000, -1, 1'b0, 1'b0);
    check_val("s4_done_cnt", 128'(done_at.size()), 128'(2));
    check_val("s4_last_done", 128'((done_at.size() > 0) ? done_at[done_at.size() - 1] : -1), 128'(2 * FRAME));
    check_val("s4_fcnt", 128'(bus.frame_cnt), 128'(2));
    repeat (3) tick();
    bus.frames = 8'd1; bus.start = 1'b1;
    observe_run(FRAME + 500, -1, -1, 1'b0, 1'b0);
    check_val("s4_restart_done", 128'(done_at.size()), 128'(1));
    check_val("s4_restart_fcnt", 128'(bus.frame_cnt), 128'(1));
    repeat (3) tick();

    // Writes to LUT 50, LUT 10 and an out-of-range address while LUT 10 streams.
    bus.frames = 8'd2; bus.start = 1'b1;
    observe_run(2 * FRAME + 500, -1, -1, 1'b0, 1'b1);
    check_val("s5_fcnt", 128'(bus.frame_cnt), 128'(2));
    repeat (3) tick();

    // rst mid-stream, then stop during the core reset phase.
    bus.frames = 8'd0; bus.start = 1'b1;
    observe_run(1000, -1, 500, 1'b0, 1'b0);
    check_val("s6_busy", 128'(bus.busy), 128'(0));
    check_val("s6_core_rst", 128'(bus.core_rst), 128'(1));
    check_val("s6_fcnt", 128'(bus.frame_cnt), 128'(0));
    bus.frames = 8'd2; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    rst_low = 1'b0;
    repeat (49) begin
      tick();
      if (!bus.core_rst) rst_low = 1'b1;
    end
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    check_val("s6_stop_busy", 128'(bus.busy), 128'(0));
    repeat (20) begin
      tick();
      if (!bus.core_rst) rst_low = 1'b1;
    end
    check_val("s6_rst_held", 128'(rst_low), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
